// File: rtl/div16_if.sv
// div16_if: operand/result handshake bundle for the sequential divider.
// Build macro DIV_SIGNED_EN adds the is_signed request bit.
interface div16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // requester side (datapath controller)
    modport master (
`ifdef DIV_SIGNED_EN
        output is_signed,
`endif
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // divider side
    modport slave (
`ifdef DIV_SIGNED_EN
        input  is_signed,
`endif
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div16_seq.sv
// div16_seq: restoring divider, one quotient bit per clock, start/busy/done.
// Each step is a single WIDTH+1-bit subtract built as add-with-inverted-operand.
// Build macro DIV_SIGNED_EN: two's complement mode selected by is_signed.
module div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    div16_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] p;        // partial remainder
    logic [WIDTH-1:0] dvd;      // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] d;        // divisor magnitude
    logic [WIDTH-1:0] qs;       // quotient bits accumulated so far
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;
    logic             neg_q;
    logic             neg_r;

    // operand magnitudes and result sign requests at the accepting edge
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
    assign dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
`else
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
`endif
    assign dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    // one restoring step: T = P' - D, keep T when it did not borrow
    logic [WIDTH:0]   p_ext;
    logic [WIDTH+1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             unused_bits;

    assign p_ext = {p, dvd[WIDTH-1]};
    assign sum   = {1'b0, p_ext} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign cout  = sum[WIDTH+1];
    // a kept difference is below D and an unkept P' is below D, so WIDTH bits suffice
    assign p_nxt = cout ? sum[WIDTH-1:0] : p_ext[WIDTH-1:0];
    assign q_nxt = {qs[WIDTH-2:0], cout};
    // sign fix-up folded into the last step so latency is the same in both modes
    assign q_fin = neg_q ? (~q_nxt + 1'b1) : q_nxt;
    assign r_fin = neg_r ? (~p_nxt + 1'b1) : p_nxt;
    assign unused_bits = ^{sum[WIDTH], p_ext[WIDTH]};

    // control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            dvd   <= '0;
            d     <= '0;
            qs    <= '0;
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dbz_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            // no iteration needed: fixed result straight to DONE
                            state <= DONE;
                            quo_r <= '1;
                            rem_r <= bus.dividend;
                            dbz_r <= 1'b1;
                        end else begin
                            state <= RUN;
                            dvd   <= dvd_mag;
                            d     <= dvs_mag;
                            p     <= '0;
                            qs    <= '0;
                            cnt   <= '0;
                            neg_q <= dvd_neg ^ dvs_neg;
                            neg_r <= dvd_neg;
                            dbz_r <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is ignored here; the operation runs to completion
                    p   <= p_nxt;
                    qs  <= q_nxt;
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        quo_r <= q_fin;
                        rem_r <= r_fin;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule
